// File: rtl/core_pkg.sv
// core_pkg: constants and types shared by the rename / retire slice of the core.
//   NUM_PREG  - physical register count (IDs 0..NUM_PREG-1)
//   NUM_AREG  - architectural register count (p0..p(NUM_AREG-1) mapped at reset)
//   PREG_W    - physical register ID width
//   preg_t    - physical register ID type
//   OPC_S_TYPE, NOP_INSN - decode constants rename uses to spot instructions
//                          without a destination
package core_pkg;

  localparam int NUM_PREG = 64;
  localparam int NUM_AREG = 32;
  localparam int PREG_W   = 6;

  // Store major opcode: S-type instructions carry no destination register.
  localparam logic [6:0]  OPC_S_TYPE = 7'b0100011;
  // Canonical NOP (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  typedef logic [PREG_W-1:0] preg_t;

endpackage

// File: rtl/circ_fifo.sv
// circ_fifo: generic circular FIFO with a reset-preload hook.
//   clk, rstn     - clock, synchronous active-low reset
//   preload_data  - contents loaded into every storage slot at reset
//   preload_tail  - tail pointer value loaded at reset (head resets to 0)
//   push/push_data- write one entry at the tail (ignored when full)
//   pop           - advance the head (ignored when empty)
//   pop_data      - entry at the head, read combinationally
//   empty, full   - pointer-derived status
//   count         - number of stored entries
// DEPTH must be a power of two so that the extra wrap bit on each pointer
// makes full/empty distinguishable and the low bits wrap for free.
module circ_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 6,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] preload_data [DEPTH],
  input  logic [PTR_W:0]   preload_tail,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W:0]   head_r;
  logic [PTR_W:0]   tail_r;
  logic             push_en_s;
  logic             pop_en_s;

  // Status, head read and qualified push/pop strobes.
  always_comb begin
    empty     = (head_r == tail_r);
    full      = (head_r[PTR_W] != tail_r[PTR_W]) &&
                (head_r[PTR_W-1:0] == tail_r[PTR_W-1:0]);
    count     = tail_r - head_r;
    pop_data  = mem_r[head_r[PTR_W-1:0]];
    push_en_s = push & ~full;
    pop_en_s  = pop & ~empty;
  end

  // Storage and pointer update; reset reloads the whole array from the hook.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= preload_data[i];
      end
      head_r <= '0;
      tail_r <= preload_tail;
    end else begin
      if (push_en_s) begin
        mem_r[tail_r[PTR_W-1:0]] <= push_data;
        tail_r <= tail_r + (PTR_W+1)'(1);
      end
      if (pop_en_s) begin
        head_r <= head_r + (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/preg_free_list.sv
// preg_free_list: physical register free list between rename and retire.
//   clk, rstn        - clock, synchronous active-low reset
//   alloc_req        - rename wants one preg this cycle
//   alloc_valid      - list non-empty, alloc_preg meaningful
//   alloc_preg       - preg at the head of the list (zero-latency read)
//   alloc_stall      - alloc_req while the list is empty
//   ret_valid        - retire presents a reclaim
//   ret_old_vld      - retiring instruction had a destination
//   ret_old_preg     - superseded preg to return
//   free_count       - entries currently in the list
//   err_double_free  - sticky: returned a preg that was already free
//   err_overflow     - sticky: returned a preg while the list was full
module preg_free_list
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [PREG_W-1:0] alloc_preg,
  output logic              alloc_stall,
  input  logic              ret_valid,
  input  logic              ret_old_vld,
  input  logic [PREG_W-1:0] ret_old_preg,
  output logic [PREG_W:0]   free_count,
  output logic              err_double_free,
  output logic              err_overflow
);

  preg_t             preload_s [NUM_PREG];
  logic [PREG_W:0]   preload_tail_s;
  preg_t             head_preg_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [PREG_W:0]   fifo_count_s;
  logic              pop_s;
  logic              push_cand_s;
  logic              dbl_s;
  logic              ovf_s;
  logic              push_s;
  logic [NUM_PREG-1:0] in_free_r;
  logic              err_dbl_r;
  logic              err_ovf_r;

  // Reset image: the non-architectural pregs, in ascending order.
  always_comb begin
    for (int i = 0; i < NUM_PREG; i++) begin
      if (i < NUM_PREG - NUM_AREG) begin
        preload_s[i] = PREG_W'(NUM_AREG + i);
      end else begin
        preload_s[i] = PREG_W'(0);
      end
    end
    preload_tail_s = (PREG_W+1)'(NUM_PREG - NUM_AREG);
  end

  // Pop/push qualification. Double-free is judged on pre-edge membership, so
  // popping X while X is returned in the same cycle drops the return.
  // Overflow cannot occur while the bitmap holds, but is flagged defensively.
  always_comb begin
    pop_s       = alloc_req & ~fifo_empty_s;
    push_cand_s = ret_valid & ret_old_vld & (ret_old_preg != PREG_W'(0));
    dbl_s       = push_cand_s & in_free_r[ret_old_preg];
    ovf_s       = push_cand_s & fifo_full_s;
    push_s      = push_cand_s & ~dbl_s & ~ovf_s;
  end

  circ_fifo #(
    .DEPTH (NUM_PREG),
    .WIDTH (PREG_W)
  ) u_fifo (
    .clk          (clk),
    .rstn         (rstn),
    .preload_data (preload_s),
    .preload_tail (preload_tail_s),
    .push         (push_s),
    .push_data    (ret_old_preg),
    .pop          (pop_s),
    .pop_data     (head_preg_s),
    .empty        (fifo_empty_s),
    .full         (fifo_full_s),
    .count        (fifo_count_s)
  );

  // Membership bitmap and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_PREG; i++) begin
        in_free_r[i] <= (i >= NUM_AREG);
      end
      err_dbl_r <= 1'b0;
      err_ovf_r <= 1'b0;
    end else begin
      // A same-cycle pop and push never target the same preg (see dbl_s).
      if (pop_s) begin
        in_free_r[head_preg_s] <= 1'b0;
      end
      if (push_s) begin
        in_free_r[ret_old_preg] <= 1'b1;
      end
      err_dbl_r <= err_dbl_r | dbl_s;
      err_ovf_r <= err_ovf_r | ovf_s;
    end
  end

  // Output drive.
  always_comb begin
    alloc_valid     = ~fifo_empty_s;
    alloc_preg      = head_preg_s;
    alloc_stall     = alloc_req & fifo_empty_s;
    free_count      = fifo_count_s;
    err_double_free = err_dbl_r;
    err_overflow    = err_ovf_r;
  end

endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Physical-register free list for the out-of-order core. It is the reclaim end of the rename allocation interface.
- Rename pops free physical registers for new destinations.
- Retire pushes back the superseded mapping (old_dr) once the renaming instruction commits.
- A circular FIFO of 6-bit preg IDs, plus a membership bitmap that detects illegal double-frees.

Parameters:
- NUM_PREG, 64, total physical registers; IDs 0..NUM_PREG-1.
- NUM_AREG, 32, architectural registers; p0..p(NUM_AREG-1) are mapped at reset and are not free.
- PREG_W, 6, preg ID width, log2(NUM_PREG).

Ports:
- clk  in  1  core clock.
- rstn  in  1  reset; synchronous, active-low.
- alloc_req  in  1  rename requests one preg this cycle.
- alloc_valid  out  1  free list non-empty; alloc_preg is meaningful.
- alloc_preg  out  PREG_W  head-of-list preg ID.
- alloc_stall  out  1  equals alloc_req & ~alloc_valid; rename holds the instruction.
- ret_valid  in  1  retiring instruction presents a reclaim.
- ret_old_vld  in  1  the instruction had a destination (not S-type, NOP, or x0).
- ret_old_preg  in  PREG_W  superseded physical register to free.
- free_count  out  PREG_W+1  number of entries in the free list.
- err_double_free  out  1  sticky: push of a preg already free.
- err_overflow  out  1  sticky: push while the list is full.

Behaviour:
- Storage:
  - fifo[NUM_PREG] of PREG_W bits.
  - head and tail pointers, PREG_W+1 bits each, with a wrap bit.
  - in_free[NUM_PREG] bitmap.
- Reset (rstn=0 at posedge):
  - fifo[i] = NUM_AREG+i for i < NUM_PREG-NUM_AREG.
  - head = 0, tail = NUM_PREG-NUM_AREG, free_count = 32.
  - in_free bits 32..63 = 1, all others 0.
  - err_* = 0.
  - Outputs after reset: alloc_valid = 1, alloc_preg = 32, alloc_stall = 0.
- Reset mid-operation discards all pending state. Reset wins over any push or pop in the same cycle.
- Empty/full: empty when head == tail; full when the pointers differ only in the wrap bit.
- Pop (alloc_req & alloc_valid):
  - alloc_preg = fifo[head[PREG_W-1:0]], driven combinationally from registered state; zero-latency read.
  - At the clock edge: head increments and in_free[alloc_preg] clears.
  - alloc_req while empty is not a pop; alloc_stall = 1 and no state changes.
- Push (ret_valid & ret_old_vld & ret_old_preg != 0):
  - Normally: fifo[tail] = ret_old_preg, tail increments, in_free bit sets.
  - p0 (x0) is never freed; the push is silently ignored.
  - If in_free[ret_old_preg] is already 1, evaluated on pre-edge state, the push is dropped and err_double_free sets.
  - If full, the push is dropped and err_overflow sets.
- Simultaneous push and pop:
  - Both take effect; free_count is unchanged.
  - Popping preg X and pushing X in the same cycle is a double-free: in_free[X] is still 1 pre-edge, so the push is dropped.
- Empty plus push: there is no bypass. The pushed preg is allocatable the following cycle, so alloc_valid rises one cycle after the push edge.
- Pointers wrap modulo NUM_PREG on the low bits; the wrap bit toggles.
- free_count = tail - head, in PREG_W+1 bit arithmetic.
- Error flags clear only on reset.

Decomposition:
- Shared core package (core_pkg) holds:
  - NUM_PREG, NUM_AREG, PREG_W.
  - The S-type and NOP opcode constants already used by rename.
  - A preg_t typedef (logic [PREG_W-1:0]).
- The single natural sub-module is a generic circular FIFO, circ_fifo, parameterised by DEPTH and WIDTH with a reset-preload hook.
- preg_free_list adds to it the bitmap, the p0 filter and the error flags.

Test Plan:
- Reset, then alloc_req=1 for 32 cycles:
  - alloc_preg runs 32, 33, ... 63.
  - alloc_valid drops the cycle after the 32nd pop; free_count = 0.
  - A further alloc_req gives alloc_stall = 1.
- From empty, push ret_old_preg = 5:
  - alloc_valid = 1 the next cycle with alloc_preg = 5; free_count = 1.
  - A pop of 5 then returns free_count to 0.
- Reset; push 40, which is already free:
  - err_double_free = 1; free_count stays 32; fifo order unchanged (alloc_preg still 32).
- Reset; the same cycle pops 32 and pushes 7:
  - free_count stays 32; next alloc_preg = 33.
  - After 31 more pops, alloc_preg = 7, which confirms tail wrap ordering.
- ret_old_vld=1 with ret_old_preg=0, then ret_old_vld=0 with ret_old_preg=9:
  - No state change; no error flags set.
- Assert rstn=0 mid-stream after 10 pops and 3 pushes:
  - Next cycle free_count = 32, alloc_preg = 32, err flags = 0.
